keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column is driven before its rows are sampled (legal range 2..255).
REQ-002 Parameter DEBOUNCE, default 3: consecutive identical samples required to accept a press or a release (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rows  input  4  matrix row lines; active-low, externally pulled up.
REQ-006 cols  output  4  column drive; exactly one bit low at all times.
REQ-007 keypad  output  4  key code delivered to the downstream Elevator keypad input.
REQ-008 key_valid  output  1  keypad holds an undelivered key.
REQ-009 key_ready  input  1  consumer accepts the key; a transfer occurs when key_valid and key_ready are both high at a clock edge.
REQ-010 overflow  output  1  sticky flag: a debounced key was lost.

Function
REQ-011 The key map (row r, column c) SHALL be:
- row 0: 1 2 3 A(1010)
- row 1: 4 5 6 B(1011)
- row 2: 7 8 9 C(1100)
- row 3: *(1110) 0(0000) #(1111) D(1101)
- Digits encode as their binary value.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, EMIT and HOLD.
REQ-013 SCAN: drive the column, wait SCAN_DIV cycles, then sample rows.
- All rows high: advance to the next column, wrapping 3 to 0.
- Any row low: capture row and column, go to DEBOUNCE.
REQ-014 When several rows are low, the lowest row index SHALL win.
REQ-015 DEBOUNCE: the column stays driven and rows are sampled every SCAN_DIV cycles.
- Captured row low for DEBOUNCE samples in total: go to EMIT.
- Captured row high on any sample: return to SCAN at the same column, no key emitted.
REQ-016 EMIT SHALL last exactly one cycle and push the code to the output stage; key_valid rises on the following cycle.
REQ-017 HOLD: the column stays driven; return to SCAN at the next column only after all rows are high for DEBOUNCE consecutive samples.
- Exactly one key per press; no auto-repeat.
- Other keys pressed during HOLD are ignored.
REQ-018 keypad SHALL stay stable while key_valid is high and no transfer has occurred.
REQ-019 overflow SHALL set when a key is dropped and clear only on reset.
REQ-020 A push and a pop in the same cycle SHALL both take effect with no overflow.

Reset
REQ-021 While rst is low, outputs SHALL immediately be:
- cols=1110
- keypad=0000
- key_valid=0
- overflow=0
REQ-022 While rst is low, internal state SHALL be: state SCAN, all counters 0, storage empty.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the pending key.
REQ-024 Scanning SHALL resume at column 0 on the first clock edge after rst rises.

Configuration
REQ-025 KEYPAD_FIFO_EN defined:
- The output stage is a 4-entry FIFO; keypad and key_valid reflect its head.
- A push while 4 entries are held drops the new key and sets overflow.
REQ-026 KEYPAD_FIFO_EN undefined:
- The output stage is a single register.
- A push while key_valid is high without a transfer overwrites the held code and sets overflow.

Verification
REQ-027 Press row1/col3 for 40 cycles, key_ready=1, defaults -> exactly one transfer, keypad=1011, overflow=0.
REQ-028 Row0 low for 6 cycles at column 1 only (bounce) -> no key_valid, scanning continues at column 1 and then column 2.
REQ-029 Press 0 then #, key_ready=0 throughout:
- FIFO build: two entries; pops yield 0000 then 1111.
- Non-FIFO build: keypad=1111, overflow=1.
REQ-030 Five keys pressed with key_ready=0 in a FIFO build -> overflow=1; four pops yield the first four codes in order.
REQ-031 rst driven low during HOLD of key 5 -> cols=1110 and key_valid=0 immediately; no key emitted after release.
REQ-032 Rows 1 and 2 low together at column 0 -> single key 0100.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Key delivery handshake between the keypad scanner and its consumer.
// The scanner presents a 4-bit key code on keypad with key_valid.
// A transfer happens on any clock edge where key_valid and key_ready are both high.
interface keypad_scanner_if;
  logic [3:0] keypad;
  logic       key_valid;
  logic       key_ready;

  modport master (output keypad, output key_valid, input key_ready);
  modport slave  (input keypad, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and a buffered key output stage.
// Columns are driven one at a time (active low). Each column is held for
// SCAN_DIV cycles before the rows are sampled. A press is accepted after
// DEBOUNCE consecutive low samples, and exactly one code is emitted per press.
// The scanner then waits for a debounced release before it resumes scanning.
// Optional build macro KEYPAD_FIFO_EN selects the output stage:
//   defined   -> 4-entry FIFO; a new key is dropped when the FIFO is full.
//   undefined -> single register; a new key overwrites an undelivered one.
// In both cases a lost key sets the sticky overflow flag.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  keypad_scanner_if.master kp,
  output logic             overflow
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_NEED = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [7:0] div_q, div_d;
  logic [3:0] deb_q, deb_d;
  logic       overflow_q, overflow_d;

  logic       sample;
  logic       any_low;
  logic       row_low;
  logic [1:0] low_idx;
  logic [3:0] deb_inc;
  logic       push;
  logic [3:0] push_code;
  logic       pop;

  // Digits 1..9 follow r*3+c+1; column 3 carries A..D; row 3 is irregular.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      unique case (c)
        2'd0:    code = 4'hE;
        2'd1:    code = 4'h0;
        2'd2:    code = 4'hF;
        default: code = 4'hD;
      endcase
    end else if (c == 2'd3) begin
      code = 4'hA + {2'b00, r};
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  assign cols = ~(4'b0001 << col_q);

  // Row sampling helpers: lowest active row wins when several are low.
  always_comb begin
    any_low = ~&rows;
    row_low = ~rows[row_q];
    sample  = (div_q == DIV_LAST);
    deb_inc = deb_q + 4'd1;
    if (!rows[0])      low_idx = 2'd0;
    else if (!rows[1]) low_idx = 2'd1;
    else if (!rows[2]) low_idx = 2'd2;
    else               low_idx = 2'd3;
    push_code = key_code(row_q, col_q);
  end

  // Scan/debounce FSM next-state logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = sample ? 8'd0 : div_q + 8'd1;
    deb_d   = deb_q;
    push    = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (!any_low) begin
            col_d = col_q + 2'd1;
          end else begin
            // The scan sample itself counts as the first debounce sample.
            row_d = low_idx;
            if (DEB_NEED == 4'd1) begin
              state_d = ST_EMIT;
            end else begin
              state_d = ST_DEBOUNCE;
              deb_d   = 4'd1;
            end
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (row_low) begin
            deb_d = deb_inc;
            if (deb_inc >= DEB_NEED) state_d = ST_EMIT;
          end else begin
            state_d = ST_SCAN;
            deb_d   = 4'd0;
          end
        end
      end
      ST_EMIT: begin
        push    = 1'b1;
        state_d = ST_HOLD;
        deb_d   = 4'd0;
        div_d   = 8'd0;
      end
      ST_HOLD: begin
        if (sample) begin
          if (!any_low) begin
            deb_d = deb_inc;
            if (deb_inc >= DEB_NEED) begin
              state_d = ST_SCAN;
              col_d   = col_q + 2'd1;
              deb_d   = 4'd0;
            end
          end else begin
            deb_d = 4'd0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Scan/debounce FSM state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      row_q   <= '0;
      div_q   <= '0;
      deb_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      deb_q   <= deb_d;
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic [3:0] mem_q [4];
  logic [3:0] mem_d [4];
  logic [1:0] rd_q, rd_d;
  logic [1:0] wr_q, wr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       accept;

  // FIFO bookkeeping; a full FIFO still accepts a push when it pops in the same cycle.
  always_comb begin
    mem_d      = mem_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    pop        = (cnt_q != 3'd0) && kp.key_ready;
    accept     = push && ((cnt_q != 3'd4) || pop);
    if (push && !accept) overflow_d = 1'b1;
    if (accept) begin
      mem_d[wr_q] = push_code;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    if (accept && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!accept && pop) cnt_d = cnt_q - 3'd1;
  end

  // FIFO storage and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q      <= '{default: '0};
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign kp.keypad    = mem_q[rd_q];
  assign kp.key_valid = (cnt_q != 3'd0);
`else
  logic [3:0] hold_q, hold_d;
  logic       valid_q, valid_d;

  // Single holding register; a push over an undelivered key overwrites it.
  always_comb begin
    hold_d     = hold_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    pop        = valid_q && kp.key_ready;
    if (push) begin
      hold_d  = push_code;
      valid_d = 1'b1;
      if (valid_q && !pop) overflow_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign kp.keypad    = hold_q;
  assign kp.key_valid = valid_q;
`endif

  assign overflow = overflow_q;

endmodule
